// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one request at a time, fixed-latency stall,
// single-cycle response with byte/half/word lanes, load extension and error detection.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_next;
  logic [3:0] count, count_next;

  logic          lat_we;
  logic [1:0]    lat_size;
  logic          lat_unsigned;
  logic [AW+1:0] lat_addr;
  logic [31:0]   lat_wdata;
  logic          lat_err;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          req_err;
  logic          pend_we;
  logic [1:0]    pend_size;
  logic          pend_unsigned;
  logic [AW+1:0] pend_addr;
  logic          pend_err;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_rep;

  assign accept = (state == IDLE) && req_valid;

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11) req_err = 1'b1;
    if ((req_size == 2'b01) && req_addr[0]) req_err = 1'b1;
    if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
    if (|req_addr[31:AW+2]) req_err = 1'b1;
  end

  always_comb begin
    state_next = state;
    count_next = count;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          stall = 1'b1;
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = BUSY;
            count_next = 4'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (count == 4'd1) begin
          state_next = RESP;
          count_next = 4'd0;
        end else begin
          count_next = count - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = 4'd0;
      end
    endcase
  end

  // With LATENCY=1 the response is formed on the accept edge, before the latches hold the request.
  assign pend_we       = (state == IDLE) ? req_we            : lat_we;
  assign pend_size     = (state == IDLE) ? req_size          : lat_size;
  assign pend_unsigned = (state == IDLE) ? req_unsigned      : lat_unsigned;
  assign pend_addr     = (state == IDLE) ? req_addr[AW+1:0]  : lat_addr;
  assign pend_err      = (state == IDLE) ? req_err           : lat_err;

  assign rd_word = mem[pend_addr[AW+1:2]];
  assign rd_half = pend_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (pend_addr[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
  end

  always_comb begin
    case (pend_size)
      2'b00:   load_data = pend_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_data = pend_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= 4'd0;
      lat_we       <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= 32'd0;
      lat_err      <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (accept) begin
        lat_we       <= req_we;
        lat_size     <= req_size;
        lat_unsigned <= req_unsigned;
        lat_addr     <= req_addr[AW+1:0];
        lat_wdata    <= req_wdata;
        lat_err      <= req_err;
      end
      if ((state_next == RESP) && (state != RESP)) begin
        if (pend_err) begin
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b1;
        end else if (pend_we) begin
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b0;
        end else begin
          rsp_rdata <= load_data;
          rsp_err   <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid = (state == RESP);

  always_comb begin
    case (lat_size)
      2'b00: begin
        byte_en   = 4'b0001 << lat_addr[1:0];
        wdata_rep = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        byte_en   = lat_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{lat_wdata[15:0]}};
      end
      default: begin
        byte_en   = 4'b1111;
        wdata_rep = lat_wdata;
      end
    endcase
  end

  // Store commits on the edge that ends RESP; a reset in RESP leaves state IDLE so nothing is written.
  always_ff @(posedge clk) begin
    if ((state == RESP) && lat_we && !lat_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[lat_addr[AW+1:2]][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: lanes, extension, errors, reset abort
// and accept spacing for LATENCY 1, 2 and 4 instances sharing one request bus.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        stall,    rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall1,   rsp_valid1;
  logic [31:0] rsp_rdata1;
  logic        rsp_err1;
  logic        stall4,   rsp_valid4;
  logic [31:0] rsp_rdata4;
  logic        rsp_err4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .AW(8), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH(256), .AW(8), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall1), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  dmem_responder #(.DEPTH(256), .AW(8), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall4), .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access on the LATENCY=2 instance; request fields are scrambled after accept.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err,
                               output int lat, output int stalls);
    bit got;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    #1;
    stalls = stall ? 1 : 0;
    lat = 0; got = 1'b0; rdata = 32'hX; err = 1'bX;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(posedge clk);
      if (n == 1) begin
        #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_size = 2'b11;
        req_wdata = 32'h0BAD_0BAD; req_we = ~we;
      end
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1; lat = n; rdata = rsp_rdata; err = rsp_err;
        if (stall) stalls += 100;
      end else if (stall) begin
        stalls++;
      end
    end
    checkOutput("rsp_timeout", 32'(got), 32'd1);
  endtask

  typedef struct {
    string       tag;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] rd;
  logic        er;
  int          lt, st;
  int          first[3], second[3];

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    #12;
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    @(negedge clk); reset = 1'b1;

    vecs = '{
      '{"sw_10",   1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0},
      '{"lw_10",   1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0},
      '{"sw_20",   1'b1, 2'b10, 1'b0, 32'h20,  32'h80FF7F01, 32'h0,        1'b0},
      '{"lb_23",   1'b0, 2'b00, 1'b0, 32'h23,  32'h0,        32'hFFFFFF80, 1'b0},
      '{"lbu_23",  1'b0, 2'b00, 1'b1, 32'h23,  32'h0,        32'h00000080, 1'b0},
      '{"lb_20",   1'b0, 2'b00, 1'b0, 32'h20,  32'h0,        32'h00000001, 1'b0},
      '{"lh_22",   1'b0, 2'b01, 1'b0, 32'h22,  32'h0,        32'hFFFF80FF, 1'b0},
      '{"lhu_20",  1'b0, 2'b01, 1'b1, 32'h20,  32'h0,        32'h00007F01, 1'b0},
      '{"lbu_21",  1'b0, 2'b00, 1'b1, 32'h21,  32'h0,        32'h0000007F, 1'b0},
      '{"lw_uns",  1'b0, 2'b10, 1'b1, 32'h20,  32'h0,        32'h80FF7F01, 1'b0},
      '{"sw_30",   1'b1, 2'b10, 1'b0, 32'h30,  32'h0,        32'h0,        1'b0},
      '{"sb_31",   1'b1, 2'b00, 1'b0, 32'h31,  32'hFFFFFFAB, 32'h0,        1'b0},
      '{"sh_32",   1'b1, 2'b01, 1'b0, 32'h32,  32'hCAFE1234, 32'h0,        1'b0},
      '{"lw_30",   1'b0, 2'b10, 1'b0, 32'h30,  32'h0,        32'h1234AB00, 1'b0},
      '{"lh_21",   1'b0, 2'b01, 1'b0, 32'h21,  32'h0,        32'h0,        1'b1},
      '{"lw_22",   1'b0, 2'b10, 1'b0, 32'h22,  32'h0,        32'h0,        1'b1},
      '{"size11",  1'b0, 2'b11, 1'b0, 32'h20,  32'h0,        32'h0,        1'b1},
      '{"lw_400",  1'b0, 2'b10, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1},
      '{"sw_22",   1'b1, 2'b10, 1'b0, 32'h22,  32'h12345678, 32'h0,        1'b1},
      '{"lw_20b",  1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h80FF7F01, 1'b0},
      '{"lw_3fc",  1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0,        32'hXXXXXXXX, 1'b0}
    };

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                    rd, er, lt, st);
      if (vecs[i].exp_rdata !== 32'hXXXXXXXX)
        checkOutput({vecs[i].tag, "_rdata"}, rd, vecs[i].exp_rdata);
      checkOutput({vecs[i].tag, "_err"}, 32'(er), 32'(vecs[i].exp_err));
      checkOutput({vecs[i].tag, "_lat"}, 32'(lt), 32'd2);
      checkOutput({vecs[i].tag, "_stall"}, 32'(st), 32'd2);
    end

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h40, 32'h11111111, rd, er, lt, st);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lt, st);
    checkOutput("pre_abort_rdata", rd, 32'hDEADBEEF);

    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h40;
    req_wdata = 32'h55555555; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("abort_busy_stall", 32'(stall), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_stall", 32'(stall), 32'd0);
    checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("abort_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("abort_rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lt, st);
    checkOutput("post_abort_lw_40", rd, 32'h11111111);

    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    first = '{0, 0, 0}; second = '{0, 0, 0};
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (rsp_valid1) begin if (first[0] == 0) first[0] = c; else if (second[0] == 0) second[0] = c; end
      if (rsp_valid)  begin if (first[1] == 0) first[1] = c; else if (second[1] == 0) second[1] = c; end
      if (rsp_valid4) begin if (first[2] == 0) first[2] = c; else if (second[2] == 0) second[2] = c; end
    end
    req_valid = 1'b0;
    checkOutput("lat1_first", 32'(first[0]), 32'd1);
    checkOutput("lat1_second", 32'(second[0]), 32'd3);
    checkOutput("lat2_first", 32'(first[1]), 32'd2);
    checkOutput("lat2_second", 32'(second[1]), 32'd5);
    checkOutput("lat4_first", 32'(first[2]), 32'd4);
    checkOutput("lat4_second", 32'(second[2]), 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the MEM stage of the pipeline, which acts as the initiator of load/store requests.
- Accepts one request at a time, holds the pipeline via stall for a fixed LATENCY, then returns a one-cycle response.
- Handles byte/half/word lanes, sign/zero extension of loads, and alignment/range errors.
- Owns a DEPTH x 32 word array, little-endian.

Parameters:
- DEPTH, 256, number of 32-bit words in the array.
- AW, 8, word-index width; must equal log2(DEPTH).
- LATENCY, 2, cycles from request accept to rsp_valid; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- req_valid  input  1  MEM stage presents a load/store; held stable by initiator while stall=1.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- stall  output  1  pipeline hold; combinational.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  misaligned, out-of-range or illegal-size access; valid with rsp_valid.

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Any latched request is discarded; a pending store is never written.
  - Array contents are not reset.
- IDLE:
  - With req_valid=1 in cycle T: latch we/size/unsigned/addr/wdata.
  - LATENCY=1: next state RESP.
  - Otherwise: next state BUSY with counter=LATENCY-1.
- BUSY: decrement counter each cycle; when counter==1, next state RESP.
- Timing: rsp_valid is high exactly in cycle T+LATENCY.
- RESP: rsp_valid=1 for this cycle only; next state IDLE unconditionally.
- Throughput: one access per LATENCY+1 cycles. A request visible in the cycle after RESP is a new request.
- stall = (state==IDLE & req_valid) | (state==BUSY). Stall is 0 in RESP, so the pipeline advances on the response cycle.
- Error detection at accept time:
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:AW+2] != 0.
- On error: rsp_err=1, rsp_rdata=0, no array write.
- Store commit:
  - The array write happens at the posedge ending the RESP cycle, via byte enables.
  - Byte: lane addr[1:0] gets wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} get wdata[15:0], low byte at the lower address.
  - Word: all four lanes.
- Stores return rsp_rdata=0, rsp_err=0.
- Load:
  - Word read at index addr[AW+1:2] during RESP.
  - Select byte/half by addr[1:0]; extend to 32 bits per req_unsigned.
  - Word loads ignore req_unsigned.
- rsp_rdata/rsp_err are registered.
  - They hold their last value until the next RESP.
  - Verification checks them only while rsp_valid=1.
- Changes on req_* while state!=IDLE are ignored (values were latched at accept).
- Reset asserted during BUSY or RESP:
  - Immediate return to IDLE with outputs cleared.
  - stall may assert again once reset deasserts, if req_valid=1.

Test Plan:
- Word store then load, LATENCY=2:
  - Store word 0xDEADBEEF at 0x10: stall high for 2 cycles, rsp_valid in cycle T+2, rsp_err=0.
  - Load word at 0x10: rsp_rdata=0xDEADBEEF at T+2.
- Byte lanes and extension:
  - Set up: store word 0x80FF7F01 at 0x20.
  - lb at 0x23 -> 0xFFFFFF80.
  - lbu at 0x23 -> 0x00000080.
  - lb at 0x20 -> 0x00000001.
  - lh at 0x22 -> 0xFFFF80FF.
  - lhu at 0x20 -> 0x00007F01.
- Partial stores:
  - Set up: word 0x00000000 at 0x30.
  - sb 0xAB at 0x31, then sh 0x1234 at 0x32.
  - lw 0x30 -> 0x1234AB00.
- Errors:
  - lh at 0x21, lw at 0x22, size=11, lw at 0x400 (DEPTH=256): each gives rsp_err=1, rsp_rdata=0.
  - sw at 0x22: rsp_err=1, and a later lw 0x20 is unchanged.
- LATENCY=1 and LATENCY=4 builds: rsp_valid exactly 1 and 4 cycles after accept. Back-to-back req_valid yields accept intervals of 2 and 5 cycles.
- Reset mid-access:
  - Drop reset low during BUSY of sw 0x55555555 at 0x40: rsp_valid, stall (with req_valid=0) and rsp_* go to 0 immediately.
  - After release, lw 0x40 returns the prior contents.
